rv_mdu: RTL and testbench
=========================

Name: rv_mdu

Overview:
Parametrised iterative multiply/divide unit implementing all eight RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the multicycle RISC-V core. It sits in the execute stage beside the ALU. Operands come from the A/B stage registers, and the result is muxed into the ALUOUT write path. The control FSM starts an operation, stalls on busy, and writes back on done.

Parameters:
DPWIDTH, 32, operand/result width; must be even, >= 8.
MUL_STEP, 1, multiplier bits retired per cycle (1, 2 or 4); DPWIDTH must be divisible by MUL_STEP.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
start  in  1  request; sampled only when busy=0.
op  in  3  operation = instr funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
rs1  in  DPWIDTH  operand 1 (multiplicand / dividend).
rs2  in  DPWIDTH  operand 2 (multiplier / divisor).
kill  in  1  synchronous abort.
busy  out  1  operation in progress.
done  out  1  one-cycle pulse; result valid.
result  out  DPWIDTH  registered result; held until next completion.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, all internal registers 0. Reset mid-operation discards the operation; no done follows.
- States: IDLE, CALC, FIX.
  - IDLE: start=1 & kill=0 captures op/rs1/rs2, converts signed operands to magnitudes and records result sign, then goes to CALC. Divide special cases go directly to FIX.
  - CALC: counter runs ITER cycles, then goes to FIX.
  - FIX: applies sign correction, selects hi/lo half or quotient/remainder, registers result, pulses done, returns to IDLE.
- ITER = DPWIDTH/MUL_STEP for MUL*, DPWIDTH for DIV*/REM*.
- Latency: start sampled at end of cycle 0; CALC occupies cycles 1..ITER; FIX is cycle ITER+1; done=1 in cycle ITER+2.
  - Special divide cases: done in cycle 2.
- busy=1 in cycles 1 through ITER+1; busy=0 in the done cycle.
- Back-to-back: start in the done cycle is accepted.
- start while busy=1 is ignored (no queueing).
- Multiply:
  - Unsigned shift-add over a 2*DPWIDTH accumulator, MUL_STEP bits per cycle.
  - Signedness: MULH both operands signed; MULHSU rs1 signed, rs2 unsigned; MULHU both unsigned; MUL low half is sign-independent.
  - Final negate when signs differ.
  - MUL returns bits [DPWIDTH-1:0]; MULH* return [2*DPWIDTH-1:DPWIDTH].
- Divide:
  - Restoring, 1 quotient bit/cycle, on magnitudes.
  - Quotient sign = sign(rs1) XOR sign(rs2) for DIV.
  - Remainder takes the sign of rs1 for REM.
- Divide special cases (RISC-V spec, no trap):
  - Divisor 0: DIV/DIVU result all-ones; REM/REMU result rs1.
  - Signed overflow (rs1 = 1 followed by zeros, rs2 all-ones), DIV/REM only: DIV result rs1; REM result 0.
- Kill: in any state returns to IDLE at the next edge. Suppresses done; result unchanged. kill and start in the same cycle: kill wins, start ignored.
- Operand inputs are don't-care after the start cycle; the unit works from captured copies.
- done is never asserted without a preceding accepted start.

Decomposition:
- Shared parameter include (params.inc) holds MDU_MUL..MDU_REMU op constants (values = funct3) and MDU state encodings.
- Control FSM and MDU_* constants alongside existing ALU_* / WB_* constants. Add WB_MDU select for the writeback mux.
- One natural sub-module: rv_mdu_sign. It is combinational conditional negate/absolute value, parametrised by DPWIDTH, instantiated for operand magnitude and result fix-up.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (DPWIDTH=32, MUL_STEP=1) -> done in cycle 34, result=0xFFFFFFEB; MULHU same operands -> 0x00000006.
- MULH rs1=rs2=0x80000000 -> result=0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIVU 100/7 -> result 14, done cycle 34. REMU 100/7 -> 2. REM rs1=-7 (0xFFFFFFF9), rs2=2 -> 0xFFFFFFFF. DIV -7/2 -> 0xFFFFFFFD.
- DIV 5/0 -> 0xFFFFFFFF, done cycle 2. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, done cycle 2. REM same operands -> 0.
- Kill asserted in cycle 10 of a DIVU: no done, busy=0 next cycle, result keeps previous value. New start is then accepted. Repeat with rst_n pulsed low mid-op: all outputs 0 immediately.
- MUL_STEP=4: MUL 0x12345678 x 0x10 -> 0x23456780, done in cycle 10. Back-to-back start in the done cycle completes normally. start while busy is ignored.

Source files
------------

// File: rtl/rv_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes (funct3),
// FSM state encodings, writeback select values and small op-decode helpers.
`timescale 1ns/1ps
package rv_mdu_pkg;

  // Operation codes equal the instruction funct3 field
  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_t;

  // Control FSM states
  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_t;

  // Writeback mux selects in the execute stage; WB_MDU routes the MDU result
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_MDU = 2'd3;

  // Multiplies have funct3[2] clear
  function automatic logic op_is_mul(input mdu_op_t op);
    return ~op[2];
  endfunction

  // REM and REMU return the remainder rather than the quotient
  function automatic logic op_is_rem(input mdu_op_t op);
    return op[2] & op[1];
  endfunction

  // rs1 is interpreted as two's complement
  function automatic logic rs1_is_signed(input mdu_op_t op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // rs2 is interpreted as two's complement
  function automatic logic rs2_is_signed(input mdu_op_t op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/rv_mdu_sign.sv
// Combinational conditional two's-complement negate. Used both to take the
// magnitude of signed operands and to restore the sign of the final result.
`timescale 1ns/1ps
module rv_mdu_sign #(
  parameter int DPWIDTH = 32
) (
  input  logic [DPWIDTH-1:0] value,
  input  logic               neg,
  output logic [DPWIDTH-1:0] conv
);

  // Negate when requested, pass through otherwise
  assign conv = neg ? (~value + DPWIDTH'(1)) : value;

endmodule

// File: rtl/rv_mdu.sv
// Iterative RV32M multiply/divide unit. Multiplies use an unsigned shift-add
// over a double-width accumulator (MUL_STEP bits per cycle); divides use a
// restoring algorithm, one quotient bit per cycle. Both work on magnitudes,
// and a final FIX cycle restores the sign and picks the requested half.
`timescale 1ns/1ps
module rv_mdu
  import rv_mdu_pkg::*;
#(
  parameter int DPWIDTH  = 32,
  parameter int MUL_STEP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [DPWIDTH-1:0] rs1,
  input  logic [DPWIDTH-1:0] rs2,
  input  logic               kill,
  output logic               busy,
  output logic               done,
  output logic [DPWIDTH-1:0] result
);

  localparam int CNT_W = $clog2(DPWIDTH + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DPWIDTH / MUL_STEP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DPWIDTH - 1);
  localparam logic [DPWIDTH-1:0] MOST_NEG = {1'b1, {(DPWIDTH-1){1'b0}}};

  // Architectural state. For multiplies opnd holds |rs1| and the low half of
  // acc the multiplier; for divides opnd holds the divisor magnitude and acc
  // is {remainder, dividend/quotient}.
  mdu_state_t                 state;
  mdu_op_t                    cur_op;
  logic [DPWIDTH-1:0]         opnd;
  logic [2*DPWIDTH-1:0]       acc;
  logic [CNT_W-1:0]           cnt;
  logic                       neg_res;

  // Start-cycle decode
  mdu_op_t                    op_in;
  logic                       neg1, neg2;
  logic [DPWIDTH-1:0]         mag1, mag2;
  logic                       div_zero, div_ovf, special;
  logic [DPWIDTH-1:0]         special_val;
  logic                       res_neg_in;

  assign op_in = mdu_op_t'(op);
  assign neg1  = rs1_is_signed(op_in) & rs1[DPWIDTH-1];
  assign neg2  = rs2_is_signed(op_in) & rs2[DPWIDTH-1];

  rv_mdu_sign #(.DPWIDTH(DPWIDTH)) u_abs1 (.value(rs1), .neg(neg1), .conv(mag1));
  rv_mdu_sign #(.DPWIDTH(DPWIDTH)) u_abs2 (.value(rs2), .neg(neg2), .conv(mag2));

  // Divide special cases resolved without iterating
  always_comb begin
    div_zero    = (rs2 == '0);
    div_ovf     = (rs1 == MOST_NEG) && (rs2 == '1) &&
                  ((op_in == MDU_DIV) || (op_in == MDU_REM));
    special     = ~op_is_mul(op_in) & (div_zero | div_ovf);
    special_val = '0;
    if (div_zero)
      special_val = op_is_rem(op_in) ? rs1 : '1;
    else if (div_ovf)
      special_val = op_is_rem(op_in) ? '0 : rs1;
    // Remainder follows the dividend; product and quotient follow the XOR
    res_neg_in  = op_is_rem(op_in) ? neg1 : (neg1 ^ neg2);
  end

  // Multiply step: partial products for the low MUL_STEP multiplier bits
  logic [MUL_STEP-1:0]          digit;
  logic [DPWIDTH+MUL_STEP-1:0]  pp_terms [MUL_STEP];
  logic [DPWIDTH+MUL_STEP-1:0]  pp, mul_sum;
  logic [2*DPWIDTH-1:0]         mul_next;

  assign digit = acc[MUL_STEP-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < MUL_STEP; gi++) begin : g_pp
      assign pp_terms[gi] = digit[gi] ? ({{MUL_STEP{1'b0}}, opnd} << gi) : '0;
    end
  endgenerate

  // Accumulate partial products into the upper half, then shift right
  always_comb begin
    pp = '0;
    for (int j = 0; j < MUL_STEP; j++)
      pp = pp + pp_terms[j];
    mul_sum  = {{MUL_STEP{1'b0}}, acc[2*DPWIDTH-1:DPWIDTH]} + pp;
    mul_next = {mul_sum, acc[DPWIDTH-1:MUL_STEP]};
  end

  // Divide step: shift in next dividend bit, subtract divisor if it fits
  logic [DPWIDTH:0]     rem_shift;
  logic [DPWIDTH-1:0]   rem_sub;
  logic                 fits;
  logic [2*DPWIDTH-1:0] div_next;

  always_comb begin
    rem_shift = {acc[2*DPWIDTH-1:DPWIDTH], acc[DPWIDTH-1]};
    fits      = (rem_shift >= {1'b0, opnd});
    rem_sub   = rem_shift[DPWIDTH-1:0] - opnd;
    if (fits)
      div_next = {rem_sub, acc[DPWIDTH-2:0], 1'b1};
    else
      div_next = {acc[2*DPWIDTH-2:0], 1'b0};
  end

  // Result fix-up: sign correction on the full-width value, then half select
  logic [2*DPWIDTH-1:0] fix_in, fix_out;
  logic [DPWIDTH-1:0]   fix_val;

  always_comb begin
    if (op_is_mul(cur_op))
      fix_in = acc;
    else if (op_is_rem(cur_op))
      fix_in = {{DPWIDTH{1'b0}}, acc[2*DPWIDTH-1:DPWIDTH]};
    else
      fix_in = {{DPWIDTH{1'b0}}, acc[DPWIDTH-1:0]};
  end

  rv_mdu_sign #(.DPWIDTH(2*DPWIDTH)) u_fix (.value(fix_in), .neg(neg_res), .conv(fix_out));

  assign fix_val = (op_is_mul(cur_op) && (cur_op != MDU_MUL)) ?
                   fix_out[2*DPWIDTH-1:DPWIDTH] : fix_out[DPWIDTH-1:0];

  // Control FSM with registered busy/done/result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MDU_IDLE;
      cur_op  <= MDU_MUL;
      opnd    <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state <= MDU_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          MDU_IDLE: begin
            if (start) begin
              cur_op <= op_in;
              busy   <= 1'b1;
              if (special) begin
                // Both halves carry the answer so quotient/remainder select works
                acc     <= {special_val, special_val};
                neg_res <= 1'b0;
                state   <= MDU_FIX;
              end else begin
                neg_res <= res_neg_in;
                state   <= MDU_CALC;
                if (op_is_mul(op_in)) begin
                  opnd <= mag1;
                  acc  <= {{DPWIDTH{1'b0}}, mag2};
                  cnt  <= MUL_LAST;
                end else begin
                  opnd <= mag2;
                  acc  <= {{DPWIDTH{1'b0}}, mag1};
                  cnt  <= DIV_LAST;
                end
              end
            end
          end
          MDU_CALC: begin
            acc <= op_is_mul(cur_op) ? mul_next : div_next;
            if (cnt == '0)
              state <= MDU_FIX;
            else
              cnt <= cnt - CNT_W'(1);
          end
          MDU_FIX: begin
            result <= fix_val;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= MDU_IDLE;
          end
          default: begin
            state <= MDU_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv_mdu.sv
// Directed bench for rv_mdu: a vector table run back-to-back on a MUL_STEP=1
// and a MUL_STEP=4 instance, plus hand sequences for kill, reset mid-op and
// start-while-busy.
`timescale 1ns/1ps
module tb_rv_mdu;
  import rv_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        kill = 1'b0;
  logic        busy1, done1, busy4, done4;
  logic [31:0] result1, result4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_mdu #(.DPWIDTH(32), .MUL_STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .rs1(rs1), .rs2(rs2),
    .kill(kill), .busy(busy1), .done(done1), .result(result1));

  rv_mdu #(.DPWIDTH(32), .MUL_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op), .rs1(rs1), .rs2(rs2),
    .kill(kill), .busy(busy4), .done(done4), .result(result4));

  typedef struct {
    int          which;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic sel_done(input int w);
    return (w == 0) ? done1 : done4;
  endfunction

  function automatic logic sel_busy(input int w);
    return (w == 0) ? busy1 : busy4;
  endfunction

  function automatic logic [31:0] sel_result(input int w);
    return (w == 0) ? result1 : result4;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at #1 after a rising edge (cycle 0); returns in the done cycle
  task automatic issue(input int w, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output int cyc);
    op = o; rs1 = a; rs2 = b;
    if (w == 0) start1 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    cyc = 1;
    while (!sel_done(w) && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
    end
    res = sel_result(w);
    check("busy_low_in_done", 32'(sel_busy(w)), 32'd0);
  endtask

  task automatic expect_no_done(input int w, input int n, input string name);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (sel_done(w)) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    int          cyc;
    int          seen;

    vecs.push_back('{0, MDU_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34});
    vecs.push_back('{0, MDU_MULHU,  32'h00000007, 32'hFFFFFFFD, 32'h00000006, 34});
    vecs.push_back('{0, MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34});
    vecs.push_back('{0, MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34});
    vecs.push_back('{0, MDU_MULHSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 34});
    vecs.push_back('{0, MDU_MULH,   32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 34});
    vecs.push_back('{0, MDU_MUL,    32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 34});
    vecs.push_back('{0, MDU_DIVU,   32'd100,      32'd7,        32'd14,       34});
    vecs.push_back('{0, MDU_REMU,   32'd100,      32'd7,        32'd2,        34});
    vecs.push_back('{0, MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34});
    vecs.push_back('{0, MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34});
    vecs.push_back('{0, MDU_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34});
    vecs.push_back('{0, MDU_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34});
    vecs.push_back('{0, MDU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 2});
    vecs.push_back('{0, MDU_REM,    32'd5,        32'd0,        32'd5,        2});
    vecs.push_back('{0, MDU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 2});
    vecs.push_back('{0, MDU_REMU,   32'd5,        32'd0,        32'd5,        2});
    vecs.push_back('{0, MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2});
    vecs.push_back('{0, MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2});
    vecs.push_back('{0, MDU_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34});
    vecs.push_back('{0, MDU_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34});
    vecs.push_back('{1, MDU_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 10});
    vecs.push_back('{1, MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 10});
    vecs.push_back('{1, MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 10});
    vecs.push_back('{1, MDU_DIVU,   32'd100,      32'd7,        32'd14,       34});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy1", 32'(busy1), 32'd0);
    check("reset_done1", 32'(done1), 32'd0);
    check("reset_result1", result1, 32'd0);
    check("reset_result4", result4, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table, each op started in the done cycle of the previous one
    foreach (vecs[i]) begin
      issue(vecs[i].which, vecs[i].op, vecs[i].a, vecs[i].b, res, cyc);
      $display("vec %0d dut%0d op=%0d a=%h b=%h result=%h cycles=%0d",
               i, (vecs[i].which == 0) ? 1 : 4, vecs[i].op, vecs[i].a, vecs[i].b, res, cyc);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(cyc), 32'(vecs[i].cyc));
    end

    // Kill in cycle 10 of a REMU: result keeps the previous DIVU value
    issue(0, MDU_DIVU, 32'd100, 32'd7, res, cyc);
    check("pre_kill_result", res, 32'd14);
    op = MDU_REMU; rs1 = 32'd100; rs2 = 32'd7; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("kill_busy_cycle1", 32'(busy1), 32'd1);
    for (int c = 2; c <= 10; c++) begin
      @(posedge clk); #1;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    $display("kill: busy=%0b result=%h", busy1, result1);
    check("kill_busy_next", 32'(busy1), 32'd0);
    expect_no_done(0, 40, "kill_no_done");
    check("kill_result_held", result1, 32'd14);
    issue(0, MDU_REMU, 32'd100, 32'd7, res, cyc);
    $display("after kill: result=%h cycles=%0d", res, cyc);
    check("after_kill_result", res, 32'd2);
    check("after_kill_latency", 32'(cyc), 32'd34);

    // kill together with start in idle: start ignored
    op = MDU_DIVU; rs1 = 32'd9; rs2 = 32'd3; start1 = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; kill = 1'b0;
    check("kill_start_busy", 32'(busy1), 32'd0);
    expect_no_done(0, 40, "kill_start_no_done");
    check("kill_start_result", result1, 32'd2);

    // Start while busy is ignored (MUL_STEP=4 instance)
    op = MDU_MUL; rs1 = 32'h12345678; rs2 = 32'h00000010; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 1;
    seen = 0;
    while (!done4 && cyc < 80) begin
      if (cyc == 3) begin
        op = MDU_MULHU; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; start4 = 1'b1;
      end else begin
        start4 = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start4 = 1'b0;
    $display("busy start: result=%h cycles=%0d", result4, cyc);
    check("busy_start_result", result4, 32'h23456780);
    check("busy_start_latency", 32'(cyc), 32'd10);
    expect_no_done(1, 40, "busy_start_no_extra_done");

    // Asynchronous reset mid-operation
    op = MDU_MULHU; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    $display("reset mid-op: busy=%0b done=%0b result=%h", busy4, done4, result4);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_result4", result4, 32'd0);
    check("rst_result1", result1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_done(1, 20, "rst_no_done");
    issue(1, MDU_MUL, 32'h12345678, 32'h00000010, res, cyc);
    $display("after reset: result=%h cycles=%0d", res, cyc);
    check("after_rst_result", res, 32'h23456780);
    check("after_rst_latency", 32'(cyc), 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
